// File: rtl/bcd_rounding_pkg.sv
// bcd_rounding_pkg: shared types and constants for the six-digit BCD rounder.
//   state_t  FSM states IDLE/RIPPLE/FINISH
//   digit_t  one packed BCD digit
package bcd_rounding_pkg;
    localparam int DIGIT_W         = 4;
    localparam int NUM_DIGITS      = 6;
    localparam int BCD_MAX         = 9;
    localparam int ROUND_THRESHOLD = 5;
    localparam int RIPPLE_CYCLES   = 5;
    typedef enum logic [1:0] {IDLE, RIPPLE, FINISH} state_t;
    typedef logic [DIGIT_W-1:0] digit_t;
endpackage

// File: rtl/bcd_rounding_if.sv
// bcd_rounding_if: request/result bundle of the BCD rounder.
//   start, *_in   request strobe and the six input digits (master drives)
//   *_out, done   rounded digits and one-cycle completion pulse (slave drives)
interface bcd_rounding_if;
    logic start;
    logic done;
    bcd_rounding_pkg::digit_t hundred_thousands_in, ten_thousands_in, thousands_in;
    bcd_rounding_pkg::digit_t hundreds_in, tens_in, units_in;
    bcd_rounding_pkg::digit_t hundred_thousands_out, ten_thousands_out, thousands_out;
    bcd_rounding_pkg::digit_t hundreds_out, tens_out, units_out;
    modport master (
        output start, hundred_thousands_in, ten_thousands_in, thousands_in,
               hundreds_in, tens_in, units_in,
        input  done, hundred_thousands_out, ten_thousands_out, thousands_out,
               hundreds_out, tens_out, units_out
    );
    modport slave (
        input  start, hundred_thousands_in, ten_thousands_in, thousands_in,
               hundreds_in, tens_in, units_in,
        output done, hundred_thousands_out, ten_thousands_out, thousands_out,
               hundreds_out, tens_out, units_out
    );
endinterface

// File: rtl/bcd_rounding_digit_inc.sv
// bcd_digit_inc: one digit of the carry ripple.
//   digit, carry_in       digit under test and incoming carry
//   digit_out, carry_out  incremented (or wrapped) digit and outgoing carry
// Any digit >= 9, including non-BCD codes, wraps to 0 so the result is always defined.
module bcd_digit_inc
    import bcd_rounding_pkg::*;
(
    input  digit_t digit,
    input  logic   carry_in,
    output digit_t digit_out,
    output logic   carry_out
);
    logic wrap;
    assign wrap      = digit >= digit_t'(BCD_MAX);
    assign carry_out = carry_in & wrap;
    assign digit_out = !carry_in ? digit : wrap ? '0 : digit + digit_t'(1);
endmodule

// File: rtl/bcd_rounding.sv
// bcd_rounding: rounds a six-digit packed-BCD value to the nearest ten (half-up).
//   clk, rst  clock and synchronous active-high reset
//   bus       slave side of bcd_rounding_if (start/digits in, digits/done out)
// Start on E0 is followed by five ripple cycles (tens..hundred_thousands) and
// the registered result with done on E6.
module bcd_rounding
    import bcd_rounding_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    bcd_rounding_if.slave  bus
);
    state_t     state;
    digit_t     dig [NUM_DIGITS];
    logic       carry;
    logic [2:0] idx;
    digit_t     inc_out;
    logic       inc_carry;

    // single shared incrementer, steered to the current digit by idx
    bcd_digit_inc u_inc (
        .digit     (dig[idx]),
        .carry_in  (carry),
        .digit_out (inc_out),
        .carry_out (inc_carry)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state                     <= IDLE;
            dig                       <= '{default: '0};
            carry                     <= 1'b0;
            idx                       <= '0;
            bus.done                  <= 1'b0;
            bus.hundred_thousands_out <= '0;
            bus.ten_thousands_out     <= '0;
            bus.thousands_out         <= '0;
            bus.hundreds_out          <= '0;
            bus.tens_out              <= '0;
            bus.units_out             <= '0;
        end else begin
            case (state)
                IDLE: begin
                    bus.done <= 1'b0;
                    if (bus.start) begin
                        dig   <= '{bus.units_in, bus.tens_in, bus.hundreds_in,
                                   bus.thousands_in, bus.ten_thousands_in,
                                   bus.hundred_thousands_in};
                        carry <= bus.units_in >= digit_t'(ROUND_THRESHOLD);
                        idx   <= 3'd1;
                        state <= RIPPLE;
                    end
                end
                RIPPLE: begin
                    dig[idx] <= inc_out;
                    carry    <= inc_carry;
                    idx      <= idx + 3'd1;
                    if (idx == 3'(RIPPLE_CYCLES)) state <= FINISH;
                end
                FINISH: begin
                    // carry out of the top digit saturates to 999990
                    bus.hundred_thousands_out <= carry ? digit_t'(BCD_MAX) : dig[5];
                    bus.ten_thousands_out     <= carry ? digit_t'(BCD_MAX) : dig[4];
                    bus.thousands_out         <= carry ? digit_t'(BCD_MAX) : dig[3];
                    bus.hundreds_out          <= carry ? digit_t'(BCD_MAX) : dig[2];
                    bus.tens_out              <= carry ? digit_t'(BCD_MAX) : dig[1];
                    bus.units_out             <= '0;
                    bus.done                  <= 1'b1;
                    state                     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bcd_rounding.sv
// tb_bcd_rounding: directed scoreboard bench for bcd_rounding.
module tb_bcd_rounding;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    bcd_rounding_if bus ();
    bcd_rounding dut (.clk(clk), .rst(rst), .bus(bus));

    logic [23:0] sb[$];
    int passed = 0;
    int total  = 0;
    wire [23:0] outs = {bus.hundred_thousands_out, bus.ten_thousands_out, bus.thousands_out,
                        bus.hundreds_out, bus.tens_out, bus.units_out};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic set_in(input logic [23:0] d);
        {bus.hundred_thousands_in, bus.ten_thousands_in, bus.thousands_in,
         bus.hundreds_in, bus.tens_in, bus.units_in} = d;
    endtask

    // returns at the falling edge just after E0
    task automatic launch(input logic [23:0] d, input logic [23:0] exp, input bit push);
        @(negedge clk);
        set_in(d);
        bus.start = 1'b1;
        if (push) sb.push_back(exp);
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    // k0 = edges already elapsed since E0
    task automatic await_done(input string tag, input int k0);
        int k;
        logic [23:0] e;
        k = k0;
        while (!bus.done && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk({tag, "_lat"}, k, 6);
        e = (sb.size() != 0) ? sb.pop_front() : 24'hxxxxxx;
        chk(tag, {8'h0, outs}, {8'h0, e});
        @(negedge clk);
        chk({tag, "_pulse"}, {31'h0, bus.done}, 32'h0);
    endtask

    task automatic quiet(input string tag, input int n);
        int c;
        c = 0;
        repeat (n) begin
            @(negedge clk);
            if (bus.done) c++;
        end
        chk(tag, c, 0);
    endtask

    initial begin
        rst = 1'b1;
        bus.start = 1'b0;
        set_in(24'h0);
        repeat (3) @(negedge clk);
        chk("reset_outs", {8'h0, outs}, 32'h0);
        chk("reset_done", {31'h0, bus.done}, 32'h0);
        rst = 1'b0;

        launch(24'h012345, 24'h012350, 1); await_done("half_up", 0);
        launch(24'h012347, 24'h012350, 1); await_done("units7", 0);
        launch(24'h012344, 24'h012340, 1); await_done("units4", 0);
        launch(24'h099995, 24'h100000, 1); await_done("full_ripple", 0);
        launch(24'h999995, 24'h999990, 1); await_done("saturate", 0);
        launch(24'h0000A5, 24'h000100, 1); await_done("nonbcd_carry", 0);
        launch(24'h0000C3, 24'h0000C0, 1); await_done("nonbcd_pass", 0);

        // second start sampled on E2 must be ignored
        launch(24'h123456, 24'h123460, 1);
        @(negedge clk);
        set_in(24'h987654);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        await_done("busy", 2);
        quiet("busy_extra_done", 10);

        // reset on E3 aborts the operation
        launch(24'h876543, 24'h0, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_outs", {8'h0, outs}, 32'h0);
        chk("abort_done", {31'h0, bus.done}, 32'h0);
        quiet("abort_no_done", 10);
        launch(24'h000019, 24'h000020, 1); await_done("after_abort", 0);

        // inputs changed right after E0 must not matter
        launch(24'h045678, 24'h045680, 1);
        set_in(24'h000000);
        await_done("input_hold", 0);

        chk("sb_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
